rst_seq_gen: RTL and testbench
==============================

Name: rst_seq_gen

Overview:
- Synthesizable, parametrised reset sequencer; successor to the fixed-period bench clock/reset generator.
- Takes one clock and a synchronous active-low master reset, stretches it, then releases NUM_CH downstream reset domains one at a time with a programmable gap.
- Supports a soft-reset request and an external hold.
- Sits at the top of each design (and its bench) and drives per-domain rst/rstn pairs for the UART, FIFO and register blocks.

Parameters:
- NUM_CH, 4: number of reset channels; legal range 1..16.
- HOLD_CYCLES, 64: cycles all channels stay asserted after master reset or soft reset ends; must be >= 1.
- STAGE_GAP, 16: cycles between release of channel k and channel k+1; 0 releases all channels on the same edge.
- CNT_W, 16: width of the internal counter; must hold max(HOLD_CYCLES, STAGE_GAP).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rstn  in  1  master reset; synchronous, active-low.
- soft_rst_req  in  1  single-cycle request to re-run the full sequence.
- ext_hold  in  1  level input; while high in ASSERT, the hold counter is frozen at 0.
- rst  out  NUM_CH  per-channel reset, active-high.
- rstn_out  out  NUM_CH  per-channel reset, active-low; always equals ~rst.
- busy  out  1  high in ASSERT and RELEASE.
- done  out  1  high in RUN, when all channels are released.

Behaviour:
- Timing: all outputs are registered, with no combinational path from inputs to outputs.
- Reset (rstn=0 sampled at an edge):
  - state=ASSERT, cnt=0, ch_idx=0.
  - rst = all ones, rstn_out = all zeros, busy=1, done=0.
  - rstn overrides soft_rst_req and ext_hold.
- State ASSERT:
  - If ext_hold=1, cnt is held at 0.
  - Otherwise cnt increments each edge.
  - On the edge where cnt==HOLD_CYCLES-1 and ext_hold=0: rst[0] clears, cnt=0, ch_idx=1, state goes to RELEASE.
  - If NUM_CH==1 or STAGE_GAP==0, all channels clear on that edge and state goes directly to RUN.
- Latency: rst[0] falls on the HOLD_CYCLES-th edge after the first edge with rstn=1 and ext_hold=0.
- State RELEASE:
  - cnt increments each edge.
  - On the edge where cnt==STAGE_GAP-1: rst[ch_idx] clears, cnt=0, ch_idx increments.
  - When the last channel (NUM_CH-1) clears, state goes to RUN on that same edge.
  - Channel k falls exactly k*STAGE_GAP edges after channel 0.
  - Release order is strictly ascending index.
  - ext_hold is ignored in this state.
- State RUN:
  - rst = 0, done=1, busy=0.
  - done rises on the same edge the last channel releases.
- soft_rst_req=1 in any state (rstn=1):
  - On the next edge: state=ASSERT, cnt=0, ch_idx=0, rst = all ones, done=0, busy=1.
  - A request during ASSERT restarts the hold count.
  - A request coinciding with a release edge wins: that channel stays asserted.
- ext_hold rising during RELEASE or RUN: no effect; only soft_rst_req or rstn re-asserts resets.
- Channels already released stay released until soft_rst_req or rstn; no channel re-asserts spontaneously.
- Counter: cnt never exceeds max(HOLD_CYCLES, STAGE_GAP)-1; no wrap-around in any legal configuration.
- Elaboration: parameter violations (NUM_CH=0, HOLD_CYCLES=0, CNT_W too small) stop elaboration with an error message.

Decomposition:
- Shared package rst_seq_pkg:
  - State encoding enum: ASSERT=2'd0, RELEASE=2'd1, RUN=2'd2.
  - Function clog2-based width helper for ch_idx.
- One sub-module, rst_seq_cnt: a loadable down/up counter with clear, enable and terminal-count flag, reused for both the hold and gap phases.
- The FSM and output register bank stay in rst_seq_gen.

Test Plan:
- Cold start, NUM_CH=3, HOLD_CYCLES=8, STAGE_GAP=4, rstn low for 5 edges then high -> rst[0] falls at edge 8 after release, rst[1] at edge 12, rst[2] and done at edge 16; busy falls at edge 16.
- Same config, ext_hold high for 10 edges from rstn release -> rst[0] falls at edge 18, rst[2] at edge 26.
- soft_rst_req pulse 2 edges after done -> on the next edge rst=3'b111, done=0; rst[0] falls 8 edges after the pulse, and the full sequence repeats.
- soft_rst_req on the same edge rst[1] would release (edge 12) -> rst stays 3'b110 to 3'b111 transition, i.e. all asserted, and rst[1] never drops on that edge.
- rstn pulled low for 1 edge mid-RELEASE (edge 13) -> all channels re-assert next edge and the sequence restarts from cnt=0.
- STAGE_GAP=0, NUM_CH=4, HOLD_CYCLES=1 -> all four channels and done change on the first edge after rstn release; rstn_out==~rst on every cycle.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  // Width of the channel index; one bit minimum so a single channel still has a legal vector.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// Loadable up/down counter with clear, enable and a terminal-count compare.
module rst_seq_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic         down,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] tc_val,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = down ? (cnt_q - W'(1)) : (cnt_q + W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == tc_val);

endmodule

// File: rtl/rst_seq_gen.sv
// Reset sequencer: stretches the master reset, then releases NUM_CH domains in ascending order.
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 64,
  parameter int STAGE_GAP   = 16,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              soft_rst_req,
  input  logic              ext_hold,
  output logic [NUM_CH-1:0] rst,
  output logic [NUM_CH-1:0] rstn_out,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W   = idx_w(NUM_CH);
  localparam int MAX_CNT = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'((STAGE_GAP == 0) ? 0 : STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);
  localparam bit ONE_SHOT = (NUM_CH == 1) || (STAGE_GAP == 0);

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("rst_seq_gen: NUM_CH must be in 1..16");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("rst_seq_gen: HOLD_CYCLES must be >= 1");
  end
  if ($clog2(MAX_CNT + 1) > CNT_W) begin : g_bad_cnt_w
    $error("rst_seq_gen: CNT_W too small for max(HOLD_CYCLES, STAGE_GAP)");
  end

  state_e             state_q, state_d;
  logic [NUM_CH-1:0]  rst_q, rst_d;
  logic [IDX_W-1:0]   ch_idx_q, ch_idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cnt_clr, cnt_en, cnt_tc;
  logic [CNT_W-1:0]   tc_val;

  // One counter serves both phases; only the terminal value changes with the state.
  assign tc_val = (state_q == ST_ASSERT) ? HOLD_TC : GAP_TC;

  rst_seq_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (cnt_clr),
    .load     (1'b0),
    .en       (cnt_en),
    .down     (1'b0),
    .load_val ('0),
    .tc_val   (tc_val),
    .tc       (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    rst_d    = rst_q;
    ch_idx_d = ch_idx_q;
    busy_d   = busy_q;
    done_d   = done_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    if (soft_rst_req) begin
      state_d  = ST_ASSERT;
      rst_d    = '1;
      ch_idx_d = '0;
      busy_d   = 1'b1;
      done_d   = 1'b0;
      cnt_clr  = 1'b1;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (ext_hold) begin
            cnt_clr = 1'b1;
          end else if (cnt_tc) begin
            cnt_clr = 1'b1;
            if (ONE_SHOT) begin
              rst_d   = '0;
              state_d = ST_RUN;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              rst_d[0] = 1'b0;
              ch_idx_d = IDX_W'(1);
              state_d  = ST_RELEASE;
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
        ST_RELEASE: begin
          if (cnt_tc) begin
            cnt_clr          = 1'b1;
            rst_d[ch_idx_q]  = 1'b0;
            if (ch_idx_q == LAST_CH) begin
              state_d = ST_RUN;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              ch_idx_d = ch_idx_q + IDX_W'(1);
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
        ST_RUN: begin
          cnt_clr = 1'b1;
        end
        default: begin
          state_d = ST_ASSERT;
          rst_d   = '1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= ST_ASSERT;
      rst_q    <= '1;
      ch_idx_q <= '0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rst_q    <= rst_d;
      ch_idx_q <= ch_idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign rst      = rst_q;
  assign rstn_out = ~rst_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Scoreboard bench: two sequencer configurations, expected outputs queued per edge and checked by monitors.
module tb_rst_seq_gen;

  typedef struct {
    int         tag;
    logic [3:0] rst;
    logic       done;
    logic       busy;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 3 channels, hold 8, gap 4
  logic       rstn_a = 1'b0, soft_a = 1'b0, hold_a = 1'b0;
  logic [2:0] rst_a, rstn_out_a;
  logic       busy_a, done_a;

  // Instance B: 4 channels, hold 1, gap 0
  logic       rstn_b = 1'b0, soft_b = 1'b0, hold_b = 1'b0;
  logic [3:0] rst_b, rstn_out_b;
  logic       busy_b, done_b;

  rst_seq_gen #(.NUM_CH(3), .HOLD_CYCLES(8), .STAGE_GAP(4), .CNT_W(16)) dut_a (
    .clk(clk), .rstn(rstn_a), .soft_rst_req(soft_a), .ext_hold(hold_a),
    .rst(rst_a), .rstn_out(rstn_out_a), .busy(busy_a), .done(done_a)
  );

  rst_seq_gen #(.NUM_CH(4), .HOLD_CYCLES(1), .STAGE_GAP(0), .CNT_W(4)) dut_b (
    .clk(clk), .rstn(rstn_b), .soft_rst_req(soft_b), .ext_hold(hold_b),
    .rst(rst_b), .rstn_out(rstn_out_b), .busy(busy_b), .done(done_b)
  );

  exp_t q_a[$];
  exp_t q_b[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string nm, input int tag,
                     input logic [3:0] ar, input logic [3:0] er,
                     input logic [3:0] arn, input logic [3:0] ern,
                     input logic ad, input logic ed, input logic ab, input logic eb);
    vectors++;
    if (ar !== er || arn !== ern || ad !== ed || ab !== eb) begin
      miscompares++;
      $display("FAIL %s step %0d: got rst=%b rstn_out=%b done=%b busy=%b, expected rst=%b rstn_out=%b done=%b busy=%b",
               nm, tag, ar, arn, ad, ab, er, ern, ed, eb);
    end else begin
      $display("ok   %s step %0d: rst=%b rstn_out=%b done=%b busy=%b", nm, tag, ar, arn, ad, ab);
    end
  endtask

  // Channel k of A releases at edge t0 + 4k; done with the last channel.
  function automatic exp_t exp_a(input int e, input int t0);
    exp_t x;
    x.tag  = e;
    x.rst  = 4'b0000;
    for (int k = 0; k < 3; k++) x.rst[k] = (e < t0 + 4 * k);
    x.done = (e >= t0 + 8);
    x.busy = !x.done;
    return x;
  endfunction

  task automatic step_a(input logic r, input logic s, input logic h, input exp_t x);
    @(negedge clk);
    rstn_a = r; soft_a = s; hold_a = h;
    @(posedge clk);
    q_a.push_back(x);
  endtask

  task automatic step_b(input int tag, input logic r, input logic s, input logic h,
                        input logic [3:0] er, input logic ed, input logic eb);
    exp_t x;
    x.tag = tag; x.rst = er; x.done = ed; x.busy = eb;
    @(negedge clk);
    rstn_b = r; soft_b = s; hold_b = h;
    @(posedge clk);
    q_b.push_back(x);
  endtask

  task automatic stim_a();
    exp_t x;
    int   t0;
    logic r, s, h;
    for (int i = 0; i < 5; i++) begin
      x = exp_a(-5 + i, 8);
      step_a(1'b0, 1'b0, 1'b0, x);
    end
    t0 = 8;
    for (int e = 1; e <= 108; e++) begin
      r = 1'b1; s = 1'b0; h = 1'b0;
      if (e == 18) begin s = 1'b1; t0 = 26; end  // 2 edges after done
      if (e == 36) begin s = 1'b1; t0 = 44; end  // fresh run
      if (e == 48) begin s = 1'b1; t0 = 56; end  // coincides with rst[1] release
      if (e == 61) begin r = 1'b0; t0 = 69; end  // master reset mid-RELEASE
      if (e == 80) begin r = 1'b0; t0 = 98; end  // reset, then 10 held edges
      if ((e >= 81 && e <= 90) || (e >= 100 && e <= 108)) h = 1'b1;
      x = exp_a(e, t0);
      step_a(r, s, h, x);
    end
  endtask

  task automatic stim_b();
    step_b(1, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b1);
    step_b(2, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b1);
    step_b(3, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    step_b(4, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0);
    step_b(5, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b1);
    step_b(6, 1'b1, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b1);
    step_b(7, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    step_b(8, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b1);
    step_b(9, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
  endtask

  always @(posedge clk) begin
    #1;
    while (q_a.size() != 0) begin
      exp_t x;
      x = q_a.pop_front();
      chk("A", x.tag, {1'b0, rst_a}, x.rst, {1'b0, rstn_out_a}, {1'b0, ~x.rst[2:0]},
          done_a, x.done, busy_a, x.busy);
    end
    while (q_b.size() != 0) begin
      exp_t x;
      x = q_b.pop_front();
      chk("B", x.tag, rst_b, x.rst, rstn_out_b, ~x.rst, done_b, x.done, busy_b, x.busy);
    end
  end

  initial begin
    fork
      stim_a();
      stim_b();
    join
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, expected 0/0", q_a.size(), q_b.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
